fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited requests to instruction memory,
// epoch-tagged in-flight tracking and an ordered output queue toward decode.
`ifndef DataBusBits
`define DataBusBits 64
`endif

module fetch_stage #(
  parameter logic [`DataBusBits-1:0] RESET_PC = '0,
  parameter int unsigned             DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [`DataBusBits-1:0]  PC,
  input  logic [`DataBusBits-1:0]  PCPrediction,
  output logic                     imem_req,
  output logic [`DataBusBits-1:0]  imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [`DataBusBits-1:0]  redirectPC,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [31:0]              if_instr,
  output logic [`DataBusBits-1:0]  if_PC,
  output logic [`DataBusBits-1:0]  if_predPC
);

  localparam int unsigned AW = `DataBusBits;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [AW-1:0] pc_q, pc_d;
  logic          epoch_q, epoch_d;

  logic [CW-1:0] inflCnt_q, inflCnt_d;
  logic [PW-1:0] inflWr_q, inflWr_d;
  logic [PW-1:0] inflRd_q, inflRd_d;
  logic [AW-1:0] inflPc_q    [DEPTH];
  logic [AW-1:0] inflPred_q  [DEPTH];
  logic          inflEpoch_q [DEPTH];

  logic [CW-1:0] queueCnt_q, queueCnt_d;
  logic [PW-1:0] qWr_q, qWr_d;
  logic [PW-1:0] qRd_q, qRd_d;
  logic [31:0]   qInstr_q [DEPTH];
  logic [AW-1:0] qPc_q    [DEPTH];
  logic [AW-1:0] qPred_q  [DEPTH];

  logic [CW:0] creditsUsed;
  logic        grant;
  logic        rspValid;
  logic        rspKeep;
  logic        deq;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + PW'(1);
  endfunction

  // Requests are gated by reset so nothing is issued while it is held.
  assign creditsUsed = {1'b0, inflCnt_q} + {1'b0, queueCnt_q};
  assign imem_req    = reset & ~redirect & (creditsUsed < DEPTH_W);
  assign grant       = imem_req & imem_gnt;
  assign rspValid    = imem_rvalid & (inflCnt_q != '0);
  assign rspKeep     = rspValid & ~redirect & (inflEpoch_q[inflRd_q] == epoch_q);

  assign PC        = pc_q;
  assign imem_addr = pc_q;

  assign if_valid  = (queueCnt_q != '0);
  assign deq       = if_valid & if_ready;
  assign if_instr  = if_valid ? qInstr_q[qRd_q] : '0;
  assign if_PC     = if_valid ? qPc_q[qRd_q]    : '0;
  assign if_predPC = if_valid ? qPred_q[qRd_q]  : '0;

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (redirect) begin
      pc_d    = redirectPC;
      epoch_d = ~epoch_q;
    end else if (grant) begin
      pc_d = PCPrediction;
    end
  end

  // In-flight entries survive a redirect; their stale epoch drops the response.
  always_comb begin
    inflCnt_d = inflCnt_q;
    inflWr_d  = inflWr_q;
    inflRd_d  = inflRd_q;
    if (grant) inflWr_d = nextPtr(inflWr_q);
    if (rspValid) inflRd_d = nextPtr(inflRd_q);
    if (grant && !rspValid) begin
      inflCnt_d = inflCnt_q + CW'(1);
    end else if (!grant && rspValid) begin
      inflCnt_d = inflCnt_q - CW'(1);
    end
  end

  always_comb begin
    queueCnt_d = queueCnt_q;
    qWr_d      = qWr_q;
    qRd_d      = qRd_q;
    if (redirect) begin
      queueCnt_d = '0;
      qWr_d      = '0;
      qRd_d      = '0;
    end else begin
      if (rspKeep) qWr_d = nextPtr(qWr_q);
      if (deq) qRd_d = nextPtr(qRd_q);
      if (rspKeep && !deq) begin
        queueCnt_d = queueCnt_q + CW'(1);
      end else if (!rspKeep && deq) begin
        queueCnt_d = queueCnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      epoch_q    <= 1'b0;
      inflCnt_q  <= '0;
      inflWr_q   <= '0;
      inflRd_q   <= '0;
      queueCnt_q <= '0;
      qWr_q      <= '0;
      qRd_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      inflCnt_q  <= inflCnt_d;
      inflWr_q   <= inflWr_d;
      inflRd_q   <= inflRd_d;
      queueCnt_q <= queueCnt_d;
      qWr_q      <= qWr_d;
      qRd_q      <= qRd_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inflPc_q[i]    <= '0;
        inflPred_q[i]  <= '0;
        inflEpoch_q[i] <= 1'b0;
      end
    end else if (grant) begin
      inflPc_q[inflWr_q]    <= pc_q;
      inflPred_q[inflWr_q]  <= PCPrediction;
      inflEpoch_q[inflWr_q] <= epoch_q;
    end
  end

  // Credit accounting guarantees a free slot whenever a response is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        qInstr_q[i] <= '0;
        qPc_q[i]    <= '0;
        qPred_q[i]  <= '0;
      end
    end else if (rspKeep) begin
      qInstr_q[qWr_q] <= imem_rdata;
      qPc_q[qWr_q]    <= inflPc_q[inflRd_q];
      qPred_q[qWr_q]  <= inflPred_q[inflRd_q];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// memory/decode/redirect traffic checked against a queue-based reference model.
module tb_fetch_stage;

  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] PC, PCPrediction, imem_addr, redirectPC, if_PC, if_predPC;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, if_valid, if_ready;
  logic [31:0] imem_rdata, if_instr;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] pred;
    logic        ep;
  } inflT;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] pred;
  } outT;

  inflT        inflQ[$];
  outT         outQ[$];
  logic [63:0] mPc;
  logic        mEpoch;
  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;

  always #5 clk = ~clk;

  // Predictor stand-in: a taken branch at 0x8 and a few far jumps, else PC+4.
  function automatic logic [63:0] predFn(input logic [63:0] pc);
    if (pc == 64'h8) return 64'h100;
    if (pc[6:2] == 5'h1F) return pc + 64'h200;
    return pc + 64'h4;
  endfunction

  assign PCPrediction = predFn(PC);

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .PC(PC),
    .PCPrediction(PCPrediction),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirectPC(redirectPC),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_PC(if_PC),
    .if_predPC(if_predPC)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    inflQ.delete();
    outQ.delete();
    mPc    = RESET_PC;
    mEpoch = 1'b0;
  endtask

  task automatic checkOutput();
    logic expReq;
    expReq = reset && !redirect && ((inflQ.size() + outQ.size()) < DEPTH);
    checkVal("imem_req", 64'(imem_req), 64'(expReq));
    checkVal("PC", PC, mPc);
    checkVal("imem_addr", imem_addr, mPc);
    checkVal("if_valid", 64'(if_valid), 64'(outQ.size() != 0));
    if (outQ.size() != 0) begin
      checkVal("if_instr", 64'(if_instr), 64'(outQ[0].instr));
      checkVal("if_PC", if_PC, outQ[0].pc);
      checkVal("if_predPC", if_predPC, outQ[0].pred);
    end else if (!reset) begin
      checkVal("if_instr_rst", 64'(if_instr), 64'h0);
      checkVal("if_PC_rst", if_PC, 64'h0);
      checkVal("if_predPC_rst", if_predPC, 64'h0);
    end
  endtask

  // Advances the reference model by one clock using the inputs now applied.
  task automatic updateModel();
    logic req;
    inflT e;
    outT  o;
    if (!reset) begin
      clearModel();
      return;
    end
    req = !redirect && ((inflQ.size() + outQ.size()) < DEPTH);
    if (if_ready && outQ.size() != 0) begin
      void'(outQ.pop_front());
      delivered++;
    end
    if (imem_rvalid && inflQ.size() != 0) begin
      e = inflQ.pop_front();
      if (!redirect && e.ep == mEpoch) begin
        o.instr = imem_rdata;
        o.pc    = e.pc;
        o.pred  = e.pred;
        outQ.push_back(o);
      end
    end
    if (redirect) begin
      outQ.delete();
      mPc    = redirectPC;
      mEpoch = ~mEpoch;
    end else if (req && imem_gnt) begin
      e.pc   = mPc;
      e.pred = predFn(mPc);
      e.ep   = mEpoch;
      inflQ.push_back(e);
      mPc = predFn(mPc);
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic applyStimulus(input logic gnt, input logic rv, input logic rdy,
                               input logic redir, input logic [63:0] rpc);
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = $urandom;
    if_ready    = rdy;
    redirect    = redir;
    redirectPC  = rpc;
    #1;
    checkOutput();
    updateModel();
    @(negedge clk);
  endtask

  task automatic randomStep(input int gntPct, input int rvPct, input int rdyPct,
                            input int redirPct, input int spurPct);
    logic rv;
    logic [63:0] rpc;
    if (inflQ.size() != 0) rv = ($urandom_range(0, 99) < rvPct);
    else rv = ($urandom_range(0, 99) < spurPct);
    rpc = 64'($urandom_range(0, 1023)) << 2;
    applyStimulus($urandom_range(0, 99) < gntPct, rv, $urandom_range(0, 99) < rdyPct,
                  $urandom_range(0, 99) < redirPct, rpc);
  endtask

  task automatic steadyStep();
    applyStimulus(1'b1, inflQ.size() != 0, 1'b1, 1'b0, 64'h0);
  endtask

  initial begin
    reset       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirectPC  = '0;
    if_ready    = 1'b0;
    clearModel();
    #1;
    checkOutput();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    reset = 1'b1;
    $display("[TB] reset released, steady fetch");

    for (int i = 0; i < 12; i++) steadyStep();

    $display("[TB] decode stall and resume");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, inflQ.size() != 0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 6; i++) steadyStep();

    $display("[TB] redirect with two requests in flight");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 64'h400);
    for (int i = 0; i < 8; i++) steadyStep();

    $display("[TB] redirect coincident with response and transfer");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, inflQ.size() != 0, 1'b1, 1'b1, 64'h800);
    for (int i = 0; i < 8; i++) steadyStep();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) randomStep(70, 60, 70, 5, 3);
    for (int i = 0; i < 100; i++) randomStep(95, 90, 95, 1, 0);

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    if_ready    = 1'b0;
    #2;
    reset = 1'b0;
    clearModel();
    #1;
    checkOutput();
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 10; i++) steadyStep();
    for (int i = 0; i < 60; i++) randomStep(80, 70, 80, 4, 2);

    $display("[TB] delivered %0d instructions", delivered);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
